// File: rtl/cpu_oci_trace_capture_fifo.sv
// Per-core OCI trace capture FIFO: snapshots DCT slot buffer + count on each
// strobe, queues them FWFT, drains over valid/ready, and sequences end-of-test.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   dct_buffer/count/valid capture input (slot 0 in the low SLOT_W bits)
//   test_ending           end-of-test request (level or pulse)
//   test_has_ended        testbench finished (level)
//   out_valid/buffer/count head entry; out_ready pops it
//   ovf_count             saturating count of captures dropped while full
//   count_err             sticky, a capture carried dct_count > SLOTS
//   late_drop             sticky, a capture arrived after RUN
//   done                  flush complete
module cpu_oci_trace_capture_fifo #(
   parameter int SLOT_W = 2,
   parameter int SLOTS  = 15,
   parameter int CNT_W  = 4,
   parameter int DEPTH  = 8,
   parameter int OVF_W  = 8
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [SLOT_W*SLOTS-1:0]   dct_buffer,
   input  logic [CNT_W-1:0]          dct_count,
   input  logic                      dct_valid,
   input  logic                      test_ending,
   input  logic                      test_has_ended,
   output logic                      out_valid,
   output logic [SLOT_W*SLOTS-1:0]   out_buffer,
   output logic [CNT_W-1:0]          out_count,
   input  logic                      out_ready,
   output logic [OVF_W-1:0]          ovf_count,
   output logic                      count_err,
   output logic                      late_drop,
   output logic                      done
);

   localparam int BUF_W = SLOT_W * SLOTS;
   localparam int AW    = $clog2(DEPTH);

   localparam logic [CNT_W-1:0] SLOTS_C = CNT_W'(SLOTS);
   localparam logic [AW:0]      DEPTH_C = (AW + 1)'(DEPTH);

   typedef enum logic [1:0] {
      RUN,
      FLUSH,
      FIN
   } state_t;

   logic [BUF_W-1:0] mem_buf [DEPTH];
   logic [CNT_W-1:0] mem_cnt [DEPTH];

   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    wr_ptr;
   logic [AW:0]      occ;
   logic [AW:0]      occ_next;
   state_t           state;
   state_t           state_next;

   logic [OVF_W-1:0] ovf_q;
   logic             count_err_q;
   logic             late_q;

   logic             cap;
   logic             in_run;
   logic             full;
   logic             pop;
   logic             push;
   logic             drop_ovf;
   logic             over;
   logic [CNT_W-1:0] cnt_c;
   logic [BUF_W-1:0] buf_m;

   // Clamp the count and zero every slot at or above the stored count.
   always_comb begin
      over  = dct_count > SLOTS_C;
      cnt_c = over ? SLOTS_C : dct_count;
      buf_m = '0;
      for (int i = 0; i < SLOTS; i++) begin
         if (i < int'(cnt_c)) begin
            buf_m[i*SLOT_W +: SLOT_W] = dct_buffer[i*SLOT_W +: SLOT_W];
         end
      end
   end

   assign cap    = dct_valid && (dct_count != '0);
   assign in_run = (state == RUN);
   assign full   = (occ == DEPTH_C);

   // Empty or finished FIFO never presents data, so out_ready is
   // ignored there and the head outputs read as zero.
   assign out_valid  = (occ != '0) && (state != FIN);
   assign out_buffer = out_valid ? mem_buf[rd_ptr] : '0;
   assign out_count  = out_valid ? mem_cnt[rd_ptr] : '0;

   assign pop      = out_valid && out_ready;
   // A full FIFO still accepts when the head leaves in the same cycle.
   assign push     = in_run && cap && (!full || pop);
   assign drop_ovf = in_run && cap && full && !pop;

   always_comb begin
      occ_next = occ;
      unique case ({push, pop})
         2'b10:   occ_next = occ + 1'b1;
         2'b01:   occ_next = occ - 1'b1;
         default: occ_next = occ;
      endcase
   end

   always_comb begin
      state_next = state;
      unique case (state)
         RUN: begin
            if (test_ending || test_has_ended) begin
               state_next = FLUSH;
            end
         end
         FLUSH: begin
            if ((occ_next == '0) && test_has_ended) begin
               state_next = FIN;
            end
         end
         FIN:     state_next = FIN;
         default: state_next = RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_buf[wr_ptr] <= buf_m;
         mem_cnt[wr_ptr] <= cnt_c;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         occ         <= '0;
         state       <= RUN;
         ovf_q       <= '0;
         count_err_q <= 1'b0;
         late_q      <= 1'b0;
      end else begin
         state <= state_next;
         occ   <= occ_next;
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (drop_ovf && (ovf_q != '1)) begin
            ovf_q <= ovf_q + 1'b1;
         end
         if (in_run && cap && over) begin
            count_err_q <= 1'b1;
         end
         if (!in_run && cap) begin
            late_q <= 1'b1;
         end
      end
   end

   assign ovf_count = ovf_q;
   assign count_err = count_err_q;
   assign late_drop = late_q;
   assign done      = (state == FIN);

endmodule
